// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 VGA raster timing generator and pixel coordinate source
//   clk, reset (async, active-high)         -> system clock and reset
//   x, y [9:0]                              -> current pixel coordinate (0..H_TOTAL-1, 0..V_TOTAL-1)
//   hsync, vsync                            -> active-low sync pulses for the connector
//   video_on                                -> high inside the visible 640x480 window
//   p_tick                                  -> one-clk pixel enable, every CLK_DIV clocks
//   frame_start                             -> one-clk pulse on the tick that wraps to (0,0)
//   frame_cnt [7:0]                         -> wrapping frame counter, only with VGA_FRAME_CNT_EN
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS = 10'(V_DISPLAY);
  localparam logic [9:0] HS_LO = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_HI = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_LO = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_HI = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  logic [DW-1:0] div_cnt, div_n;
  logic [9:0] x_n, y_n;
  logic h_wrap;
  // p_tick is gated by reset so it reads 0 while held in reset even when CLK_DIV=1
  always_comb begin
    p_tick = !reset && div_cnt == DIV_MAX;
    div_n = div_cnt == DIV_MAX ? '0 : div_cnt + DW'(1);
    h_wrap = p_tick && x == H_MAX;
    x_n = !p_tick ? x : h_wrap ? '0 : x + 10'd1;
    y_n = !h_wrap ? y : y == V_MAX ? '0 : y + 10'd1;
    frame_start = h_wrap && y == V_MAX;
  end
  // sync/blank are decoded from the next coordinates so they switch on the same edge as x/y
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      x <= '0;
      y <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      video_on <= 1'b1;
    end else begin
      div_cnt <= div_n;
      x <= x_n;
      y <= y_n;
      hsync <= !(x_n >= HS_LO && x_n <= HS_HI);
      vsync <= !(y_n >= VS_LO && y_n <= VS_HI);
      video_on <= x_n < H_VIS && y_n < V_VIS;
    end
  end
`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_cnt <= '0;
    else if (frame_start) frame_cnt <= frame_cnt + 8'd1;
  end
`endif
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks of vga_sync_gen at default timing and at a tiny CLK_DIV=1 raster
module tb_vga_sync_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [9:0] x0, y0, x1, y1;
  logic hs0, vs0, vo0, pt0, fs0, hs1, vs1, vo1, pt1, fs1;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] fc0, fc1;
`endif
  int checks = 0;
  int errors = 0;
  int e = 0;
  always #5 clk = ~clk;
  vga_sync_gen d0 (
    .clk(clk), .reset(reset), .x(x0), .y(y0), .hsync(hs0), .vsync(vs0),
    .video_on(vo0), .p_tick(pt0), .frame_start(fs0)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(fc0)
`endif
  );
  // small raster: H 8/2/3/2 (total 15, hsync low x=10..12), V 6/1/2/1 (total 10, vsync low y=7..8)
  vga_sync_gen #(
    .CLK_DIV(1), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) d1 (
    .clk(clk), .reset(reset), .x(x1), .y(y1), .hsync(hs1), .vsync(vs1),
    .video_on(vo1), .p_tick(pt1), .frame_start(fs1)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(fc1)
`endif
  );
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
    e += n;
  endtask
  task automatic goto0(input int yy, input int xx);
    step(4 * (yy * 800 + xx) - e);
  endtask
  task automatic release_rst();
    @(negedge clk);
    reset = 1'b0;
    e = 0;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (x0 !== 10'd0) begin errors++; $display("FAIL rst_x got %0d want 0", x0); end
    checks++; if (y0 !== 10'd0) begin errors++; $display("FAIL rst_y got %0d want 0", y0); end
    checks++; if (hs0 !== 1'b1) begin errors++; $display("FAIL rst_hsync got %b want 1", hs0); end
    checks++; if (vs0 !== 1'b1) begin errors++; $display("FAIL rst_vsync got %b want 1", vs0); end
    checks++; if (vo0 !== 1'b1) begin errors++; $display("FAIL rst_video_on got %b want 1", vo0); end
    checks++; if (pt0 !== 1'b0) begin errors++; $display("FAIL rst_p_tick got %b want 0", pt0); end
    checks++; if (fs0 !== 1'b0) begin errors++; $display("FAIL rst_frame_start got %b want 0", fs0); end
    checks++; if (pt1 !== 1'b0) begin errors++; $display("FAIL rst_p_tick_div1 got %b want 0", pt1); end
    release_rst();
    #1;
    checks++; if (pt1 !== 1'b1) begin errors++; $display("FAIL div1_p_tick_after_release got %b want 1", pt1); end
    step(2);
    checks++; if (pt0 !== 1'b0) begin errors++; $display("FAIL p_tick_clk3 got %b want 0", pt0); end
    step(1);
    checks++; if (pt0 !== 1'b1) begin errors++; $display("FAIL p_tick_clk4 got %b want 1", pt0); end
    checks++; if (x0 !== 10'd0) begin errors++; $display("FAIL x_before_tick got %0d want 0", x0); end
    step(1);
    checks++; if (pt0 !== 1'b0) begin errors++; $display("FAIL p_tick_after got %b want 0", pt0); end
    checks++; if (x0 !== 10'd1) begin errors++; $display("FAIL x_after_tick got %0d want 1", x0); end
    step(3);
    checks++; if (pt0 !== 1'b1) begin errors++; $display("FAIL p_tick_period got %b want 1", pt0); end
  endtask
  task automatic test_line();
    goto0(0, 639);
    checks++; if (x0 !== 10'd639 || vo0 !== 1'b1) begin errors++; $display("FAIL line_639 got x=%0d vo=%b want x=639 vo=1", x0, vo0); end
    goto0(0, 640);
    checks++; if (x0 !== 10'd640 || vo0 !== 1'b0) begin errors++; $display("FAIL line_640 got x=%0d vo=%b want x=640 vo=0", x0, vo0); end
    goto0(0, 655);
    checks++; if (hs0 !== 1'b1) begin errors++; $display("FAIL hsync_655 got %b want 1", hs0); end
    goto0(0, 656);
    checks++; if (hs0 !== 1'b0) begin errors++; $display("FAIL hsync_656 got %b want 0", hs0); end
    goto0(0, 751);
    checks++; if (hs0 !== 1'b0) begin errors++; $display("FAIL hsync_751 got %b want 0", hs0); end
    goto0(0, 752);
    checks++; if (hs0 !== 1'b1) begin errors++; $display("FAIL hsync_752 got %b want 1", hs0); end
    goto0(0, 799);
    checks++; if (x0 !== 10'd799 || y0 !== 10'd0) begin errors++; $display("FAIL line_799 got x=%0d y=%0d want 799,0", x0, y0); end
    goto0(1, 0);
    checks++; if (x0 !== 10'd0 || y0 !== 10'd1 || vo0 !== 1'b1 || hs0 !== 1'b1) begin
      errors++; $display("FAIL line_wrap got x=%0d y=%0d vo=%b hs=%b want 0,1,1,1", x0, y0, vo0, hs0);
    end
  endtask
  task automatic test_frame();
    int ex, ey, p, vs_low, fs_cnt, fs_last, fs_per;
    logic ehs, evs, evo, efs;
    vs_low = 0; fs_cnt = 0; fs_last = -1; fs_per = 0;
    reset = 1'b1;
    @(posedge clk);
    release_rst();
    for (int k = 1; k <= 300; k++) begin
      step(1);
      p = k % 150;
      ex = p % 15;
      ey = p / 15;
      ehs = !(ex >= 10 && ex <= 12);
      evs = !(ey >= 7 && ey <= 8);
      evo = ex < 8 && ey < 6;
      efs = ex == 14 && ey == 9;
      checks++; if (x1 !== 10'(ex) || y1 !== 10'(ey)) begin errors++; $display("FAIL frame_xy k=%0d got %0d,%0d want %0d,%0d", k, x1, y1, ex, ey); end
      checks++; if (hs1 !== ehs) begin errors++; $display("FAIL frame_hsync k=%0d got %b want %b", k, hs1, ehs); end
      checks++; if (vs1 !== evs) begin errors++; $display("FAIL frame_vsync k=%0d got %b want %b", k, vs1, evs); end
      checks++; if (vo1 !== evo) begin errors++; $display("FAIL frame_video_on k=%0d got %b want %b", k, vo1, evo); end
      checks++; if (fs1 !== efs) begin errors++; $display("FAIL frame_start k=%0d got %b want %b", k, fs1, efs); end
      checks++; if (pt1 !== 1'b1) begin errors++; $display("FAIL div1_p_tick k=%0d got %b want 1", k, pt1); end
      if (!vs1) vs_low++;
      if (fs1) begin
        if (fs_last >= 0) fs_per = k - fs_last;
        fs_last = k;
        fs_cnt++;
      end
    end
    checks++; if (vs_low != 60) begin errors++; $display("FAIL vsync_low_clks got %0d want 60", vs_low); end
    checks++; if (fs_cnt != 2) begin errors++; $display("FAIL frame_start_count got %0d want 2", fs_cnt); end
    checks++; if (fs_per != 150) begin errors++; $display("FAIL frame_period got %0d want 150", fs_per); end
  endtask
  task automatic test_midframe_reset();
    goto0(1, 660);
    checks++; if (hs0 !== 1'b0 || vo0 !== 1'b0 || x0 !== 10'd660) begin
      errors++; $display("FAIL pre_reset got x=%0d hs=%b vo=%b want 660,0,0", x0, hs0, vo0);
    end
    checks++; if (x1 !== 10'd5 || y1 !== 10'd9) begin errors++; $display("FAIL pre_reset_div1 got %0d,%0d want 5,9", x1, y1); end
    #2 reset = 1'b1;
    #1;
    checks++; if (x0 !== 10'd0 || y0 !== 10'd0) begin errors++; $display("FAIL async_rst_xy got %0d,%0d want 0,0", x0, y0); end
    checks++; if (hs0 !== 1'b1 || vs0 !== 1'b1 || vo0 !== 1'b1) begin
      errors++; $display("FAIL async_rst_sync got hs=%b vs=%b vo=%b want 1,1,1", hs0, vs0, vo0);
    end
    checks++; if (pt0 !== 1'b0 || pt1 !== 1'b0) begin errors++; $display("FAIL async_rst_tick got %b,%b want 0,0", pt0, pt1); end
    checks++; if (x1 !== 10'd0 || y1 !== 10'd0) begin errors++; $display("FAIL async_rst_div1 got %0d,%0d want 0,0", x1, y1); end
    release_rst();
    step(4);
    checks++; if (x0 !== 10'd1 || y0 !== 10'd0) begin errors++; $display("FAIL restart got %0d,%0d want 1,0", x0, y0); end
    checks++; if (x1 !== 10'd4 || y1 !== 10'd0) begin errors++; $display("FAIL restart_div1 got %0d,%0d want 4,0", x1, y1); end
  endtask
`ifdef VGA_FRAME_CNT_EN
  task automatic test_frame_cnt();
    reset = 1'b1;
    @(posedge clk);
    release_rst();
    #1;
    checks++; if (fc1 !== 8'd0 || fc0 !== 8'd0) begin errors++; $display("FAIL fcnt_reset got %0d,%0d want 0,0", fc0, fc1); end
    step(149);
    checks++; if (fc1 !== 8'd0 || fs1 !== 1'b1) begin errors++; $display("FAIL fcnt_pre got cnt=%0d fs=%b want 0,1", fc1, fs1); end
    step(1);
    checks++; if (fc1 !== 8'd1) begin errors++; $display("FAIL fcnt_first got %0d want 1", fc1); end
    step(256 * 150);
    checks++; if (fc1 !== 8'd1) begin errors++; $display("FAIL fcnt_wrap got %0d want 1", fc1); end
    checks++; if (fc0 !== 8'd0) begin errors++; $display("FAIL fcnt_default got %0d want 0", fc0); end
  endtask
`endif
  initial begin
    test_reset();
    test_line();
    test_frame();
    test_midframe_reset();
`ifdef VGA_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
